// File: rtl/drive_pkg.sv
// Shared types and constants for the drive arbiter: direction and FSM encodings,
// command word field offsets and default timing constants.
package drive_pkg;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        FWD   = 2'b01,
        REV   = 2'b10,
        BRAKE = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIVE    = 2'b01,
        DEADTIME = 2'b10
    } state_t;

    // Command word: {dirA[1:0], dutyA[6:0], dirB[1:0], dutyB[6:0]}
    localparam int unsigned CMD_W     = 18;
    localparam int unsigned DIRA_LSB  = 16;
    localparam int unsigned DUTYA_LSB = 9;
    localparam int unsigned DIRB_LSB  = 7;
    localparam int unsigned DUTYB_LSB = 0;

    localparam int unsigned DEF_CLK_HZ   = 50_000_000;
    localparam int unsigned DEF_PWM_HZ   = 80;
    localparam int unsigned DEF_PERIOD   = DEF_CLK_HZ / DEF_PWM_HZ;
    localparam int unsigned DEF_DEAD     = 50_000;
    localparam int unsigned DEF_DUTY_MAX = 80;

    function automatic logic is_reversal(input dir_t now_dir, input dir_t last_dir);
        return ((now_dir == FWD) && (last_dir == REV)) ||
               ((now_dir == REV) && (last_dir == FWD));
    endfunction

    function automatic logic [6:0] clamp_duty(input logic [6:0] duty, input logic [6:0] dmax);
        return (duty > dmax) ? dmax : duty;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One H-bridge enable: compares the shared PWM count against the duty threshold,
// forced high for brake and low for coast.
module pwm_channel
    import drive_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_PERIOD,
    parameter int unsigned CW     = $clog2(DEF_PERIOD)
) (
    input  logic [CW-1:0] count_i,
    input  logic [6:0]    duty_i,
    input  dir_t          mode_i,
    output logic          en_o
);

    localparam int unsigned STEP = PERIOD / 100;

    logic [31:0] thresh;

    always_comb begin
        thresh = 32'(duty_i) * STEP;
        unique case (mode_i)
            FWD, REV: en_o = (32'(count_i) < thresh);
            BRAKE:    en_o = 1'b1;
            default:  en_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/drive_arbiter.sv
// Fixed-priority arbiter for three motor-command sources driving a dual H-bridge,
// with dead-time on direction reversal and a shared PWM period counter.
module drive_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned PWM_HZ      = DEF_PWM_HZ,
    parameter int unsigned DEAD_CYCLES = DEF_DEAD,
    parameter int unsigned DUTY_MAX    = DEF_DUTY_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             col_req,
    input  logic             jnc_req,
    input  logic             lf_req,
    input  logic [CMD_W-1:0] col_cmd,
    input  logic [CMD_W-1:0] jnc_cmd,
    input  logic [CMD_W-1:0] lf_cmd,
    output logic [2:0]       gnt,
    output logic             hb_en_a,
    output logic             hb_en_b,
    output logic             hb_in1,
    output logic             hb_in2,
    output logic             hb_in3,
    output logic             hb_in4,
    output logic             dead
);

    localparam int unsigned PERIOD = CLK_HZ / PWM_HZ;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DW     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [CMD_W-1:0]  cmd_sel;
    logic              any_req, rev_hit, dead_done, pwm_wrap;
    dir_t              dir_a_cmd, dir_b_cmd, app_a, app_b;
    dir_t              last_a_q, last_a_d, last_b_q, last_b_d;
    logic [DW-1:0]     dead_cnt_q, dead_cnt_d;
    logic [CW-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [6:0]        duty_a_q, duty_a_d, duty_b_q, duty_b_d;
    logic              pwm_en_a, pwm_en_b;
    logic              en_a_q, en_a_d, en_b_q, en_b_d;
    logic [3:0]        pins_q, pins_d;
    logic              dead_q, dead_d;

    always_comb begin
        gnt_d   = 3'b000;
        cmd_sel = '0;
        if (col_req) begin
            gnt_d   = 3'b100;
            cmd_sel = col_cmd;
        end else if (jnc_req) begin
            gnt_d   = 3'b010;
            cmd_sel = jnc_cmd;
        end else if (lf_req) begin
            gnt_d   = 3'b001;
            cmd_sel = lf_cmd;
        end
    end

    assign any_req   = col_req | jnc_req | lf_req;
    assign dir_a_cmd = dir_t'(cmd_sel[DIRA_LSB +: 2]);
    assign dir_b_cmd = dir_t'(cmd_sel[DIRB_LSB +: 2]);
    assign rev_hit   = is_reversal(dir_a_cmd, last_a_q) | is_reversal(dir_b_cmd, last_b_q);
    assign dead_done = (state_q == DEADTIME) && (dead_cnt_q == DW'(DEAD_CYCLES - 1));
    assign pwm_wrap  = (pwm_cnt_q == CW'(PERIOD - 1));
    assign pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    assign dead_cnt_d = ((state_q == DEADTIME) && !dead_done) ? dead_cnt_q + 1'b1 : '0;

    // Next-state; a request drop takes precedence over a pending reversal.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (any_req) state_d = rev_hit ? DEADTIME : DRIVE;
            DRIVE:    if (!any_req) state_d = IDLE;
                      else if (rev_hit) state_d = DEADTIME;
            DEADTIME: if (dead_done) state_d = any_req ? DRIVE : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        app_a    = COAST;
        app_b    = COAST;
        last_a_d = last_a_q;
        last_b_d = last_b_q;
        if (state_d == DRIVE) begin
            app_a    = dir_a_cmd;
            app_b    = dir_b_cmd;
            last_a_d = dir_a_cmd;
            last_b_d = dir_b_cmd;
        end
        duty_a_d = duty_a_q;
        duty_b_d = duty_b_q;
        if (pwm_wrap) begin
            duty_a_d = (state_d == DRIVE) ? clamp_duty(cmd_sel[DUTYA_LSB +: 7], 7'(DUTY_MAX)) : '0;
            duty_b_d = (state_d == DRIVE) ? clamp_duty(cmd_sel[DUTYB_LSB +: 7], 7'(DUTY_MAX)) : '0;
        end
        pins_d = {app_a == REV, app_a == FWD, app_b == FWD, app_b == REV};
        en_a_d = pwm_en_a;
        en_b_d = pwm_en_b;
        dead_d = (state_d == DEADTIME);
    end

    pwm_channel #(.PERIOD(PERIOD), .CW(CW)) u_pwm_a (
        .count_i (pwm_cnt_q),
        .duty_i  (duty_a_q),
        .mode_i  (app_a),
        .en_o    (pwm_en_a)
    );

    pwm_channel #(.PERIOD(PERIOD), .CW(CW)) u_pwm_b (
        .count_i (pwm_cnt_q),
        .duty_i  (duty_b_q),
        .mode_i  (app_b),
        .en_o    (pwm_en_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_a_q   <= COAST;
            last_b_q   <= COAST;
            dead_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            duty_a_q   <= '0;
            duty_b_q   <= '0;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            pins_q     <= '0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_a_q   <= last_a_d;
            last_b_q   <= last_b_d;
            dead_cnt_q <= dead_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_a_q   <= duty_a_d;
            duty_b_q   <= duty_b_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            pins_q     <= pins_d;
            dead_q     <= dead_d;
        end
    end

    assign gnt     = gnt_q;
    assign hb_en_a = en_a_q;
    assign hb_en_b = en_b_q;
    assign hb_in1  = pins_q[3];
    assign hb_in2  = pins_q[2];
    assign hb_in3  = pins_q[1];
    assign hb_in4  = pins_q[0];
    assign dead    = dead_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with PERIOD scaled to 1000 and dead time to 20 cycles.
module tb_drive_arbiter;
    import drive_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        col_req, jnc_req, lf_req;
    logic [17:0] col_cmd, jnc_cmd, lf_cmd;
    logic [2:0]  gnt;
    logic        hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4, dead;
    logic [3:0]  pins;
    logic [6:0]  outs;

    int n_tests = 0;
    int n_fail  = 0;

    assign pins = {hb_in1, hb_in2, hb_in3, hb_in4};
    assign outs = {hb_en_a, hb_en_b, pins, dead};

    always #5 clk = ~clk;

    drive_arbiter #(
        .CLK_HZ      (1000),
        .PWM_HZ      (1),
        .DEAD_CYCLES (20),
        .DUTY_MAX    (80)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .col_req (col_req),
        .jnc_req (jnc_req),
        .lf_req  (lf_req),
        .col_cmd (col_cmd),
        .jnc_cmd (jnc_cmd),
        .lf_cmd  (lf_cmd),
        .gnt     (gnt),
        .hb_en_a (hb_en_a),
        .hb_en_b (hb_en_b),
        .hb_in1  (hb_in1),
        .hb_in2  (hb_in2),
        .hb_in3  (hb_in3),
        .hb_in4  (hb_in4),
        .dead    (dead)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk(input dir_t da, input int unsigned pa,
                                       input dir_t db, input int unsigned pb);
        return {da, 7'(pa), db, 7'(pb)};
    endfunction

    task automatic count_en(input int unsigned n, output int unsigned ca, output int unsigned cb);
        ca = 0;
        cb = 0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (hb_en_a) ca++;
            if (hb_en_b) cb++;
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    // Counts sampled cycles with dead high (bounded); optional jnc/col hooks mid-window.
    task automatic measure_dead(input bit hook, output int unsigned n, output bit pins_bad);
        n = 0;
        pins_bad = 1'b0;
        while ((dead === 1'b1) && (n < 200)) begin
            n++;
            if ((pins !== 4'b0000) || (hb_en_a !== 1'b0) || (hb_en_b !== 1'b0)) pins_bad = 1'b1;
            if (hook && n == 3) begin
                jnc_req = 1'b1;
                jnc_cmd = mk(REV, 30, REV, 30);
            end
            if (hook && n == 10) col_req = 1'b0;
            tick();
        end
    endtask

    initial begin
        int unsigned ca, cb, nd;
        bit          bad;

        rst_n   = 1'b0;
        col_req = 1'b0;
        jnc_req = 1'b0;
        lf_req  = 1'b0;
        col_cmd = '0;
        jnc_cmd = '0;
        lf_cmd  = '0;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'b000);
        chk("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        tick();

        // Line-follow, both forward at 27%
        lf_req = 1'b1;
        lf_cmd = mk(FWD, 27, FWD, 27);
        chk("gnt_before_edge", 32'(gnt), 32'b000);
        tick();
        chk("lf_gnt", 32'(gnt), 32'b001);
        chk("lf_pins", 32'(pins), 32'b0110);
        chk("lf_dead", 32'(dead), 32'd0);
        wait_cycles(1000);
        count_en(1000, ca, cb);
        chk("lf_en_a_270", ca, 270);
        chk("lf_en_b_270", cb, 270);

        // Collision reverse at 40% preempts: dead-time then reverse
        col_req = 1'b1;
        col_cmd = mk(REV, 40, REV, 40);
        tick();
        chk("col_gnt", 32'(gnt), 32'b100);
        measure_dead(1'b0, nd, bad);
        chk("col_dead_len", nd, 20);
        chk("col_dead_outs_low", 32'(bad), 32'd0);
        chk("col_pins", 32'(pins), 32'b1001);
        wait_cycles(1000);
        count_en(1000, ca, cb);
        chk("col_en_a_400", ca, 400);
        chk("col_en_b_400", cb, 400);

        // Duty clamp (95 -> 80) and duty zero
        col_cmd = mk(REV, 95, REV, 0);
        wait_cycles(1000);
        count_en(1000, ca, cb);
        chk("clamp_en_a_800", ca, 800);
        chk("zero_en_b_0", cb, 0);

        // Reversal of col; jnc arrives and col drops mid dead-time, no restart
        col_cmd = mk(FWD, 50, FWD, 50);
        tick();
        chk("rev2_dead_start", 32'(dead), 32'd1);
        measure_dead(1'b1, nd, bad);
        chk("rev2_dead_len", nd, 20);
        chk("rev2_dead_outs_low", 32'(bad), 32'd0);
        chk("rev2_gnt_jnc", 32'(gnt), 32'b010);
        chk("rev2_jnc_pins", 32'(pins), 32'b1001);

        // Brake on A: no dead-time, enable constant high
        jnc_cmd = mk(BRAKE, 0, REV, 30);
        tick();
        chk("brake_pins", 32'(pins), 32'b0001);
        chk("brake_dead", 32'(dead), 32'd0);
        count_en(50, ca, cb);
        chk("brake_en_a_const", ca, 50);
        jnc_req = 1'b0;
        lf_req  = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 32'b000);
        chk("idle_outs", 32'(outs), 32'd0);

        // Reversal coinciding with request drop: IDLE, last direction kept
        lf_req = 1'b1;
        lf_cmd = mk(FWD, 27, REV, 27);
        tick();
        chk("drv_pins_0101", 32'(pins), 32'b0101);
        chk("drv_dead0", 32'(dead), 32'd0);
        lf_req = 1'b0;
        lf_cmd = mk(REV, 27, REV, 27);
        tick();
        chk("drop_wins_outs", 32'(outs), 32'd0);
        lf_req = 1'b1;
        lf_cmd = mk(FWD, 27, REV, 27);
        tick();
        chk("lastdir_kept_dead0", 32'(dead), 32'd0);
        chk("lastdir_kept_pins", 32'(pins), 32'b0101);

        // Reset in the middle of dead-time
        lf_cmd = mk(REV, 27, REV, 27);
        tick();
        chk("rst_dt_enter", 32'(dead), 32'd1);
        wait_cycles(4);
        chk("rst_dt_cycle5", 32'(dead), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 32'(outs), 32'd0);
        chk("rst_async_gnt", 32'(gnt), 32'b000);
        tick();
        tick();
        rst_n  = 1'b1;
        lf_cmd = mk(FWD, 27, FWD, 27);
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'b001);
        chk("post_rst_dead0", 32'(dead), 32'd0);
        chk("post_rst_pins", 32'(pins), 32'b0110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear on rst_n low.
REQ-002 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-003 The block SHALL have parameter PWM_HZ, default 80, meaning the PWM frequency; PERIOD = CLK_HZ/PWM_HZ = 625_000 cycles.
REQ-004 The block SHALL have parameter DEAD_CYCLES, default 50_000, meaning the off time in cycles on any motor direction reversal.
REQ-005 The block SHALL have parameter DUTY_MAX, default 80, meaning the duty clamp in percent, per the H-bridge stall limit.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have ports col_req, jnc_req and lf_req, each input, 1 bit: the collision, junction and line-follow requests.
REQ-009 The block SHALL have ports col_cmd, jnc_cmd and lf_cmd, each input, 18 bits: {dirA[1:0], dutyA[6:0], dirB[1:0], dutyB[6:0]}, where dir encodes 00 coast, 01 forward, 10 reverse and 11 brake.
REQ-010 The block SHALL have port gnt, output, 3 bits: one-hot grant {col, jnc, lf}, or 000 when none is granted.
REQ-011 The block SHALL have ports hb_en_a and hb_en_b, each output, 1 bit: H-bridge enables (PWM).
REQ-012 The block SHALL have ports hb_in1, hb_in2, hb_in3 and hb_in4, each output, 1 bit: H-bridge direction inputs.
REQ-013 The block SHALL have port dead, output, 1 bit: high while dead-time is in progress.

Function
REQ-014 Grant SHALL be fixed priority (col > jnc > lf), re-evaluated every cycle and registered, so gnt follows req with 1-cycle latency.
REQ-015 The state machine SHALL have states IDLE, DRIVE and DEADTIME.
REQ-016 IDLE SHALL move to DRIVE when any req is high, and DRIVE SHALL move to IDLE when all req are low.
REQ-017 DRIVE SHALL move to DEADTIME when the granted command has dirX=forward and last_dirX=reverse (or vice versa) on either motor.
REQ-018 DEADTIME SHALL count DEAD_CYCLES cycles, then apply the currently granted command and go to DRIVE, or go to IDLE if no req is high.
REQ-019 A grant change or a new reversal request during DEADTIME SHALL NOT restart the count.
REQ-020 last_dirX SHALL update when a direction is applied, and coast/brake transitions SHALL NOT trigger dead-time.
REQ-021 Pin map: A forward gives in1=0, in2=1; A reverse gives in1=1, in2=0; B forward gives in3=1, in4=0; B reverse gives in3=0, in4=1.
REQ-022 Coast SHALL drive both inputs and the enable to 0; brake SHALL drive both inputs to 0 and the enable to constant 1.
REQ-023 In IDLE and DEADTIME, all hb_* outputs SHALL be 0, and dead SHALL be 1 only in DEADTIME.
REQ-024 One shared PWM counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-025 hb_en_X SHALL be high when count < dutyX*(PERIOD/100) and forward/reverse is applied.
REQ-026 Duty SHALL be clamped to DUTY_MAX, with duty 0 giving the enable always low.
REQ-027 Duty SHALL be latched only at count==0 (glitch-free), while direction SHALL be applied immediately in DRIVE (a reversal goes via DEADTIME).
REQ-028 When a reversal and a req drop occur in the same cycle, the req drop SHALL win and the state SHALL go to IDLE with last_dir kept.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On rst_n=0 (asynchronous), the state SHALL be IDLE, gnt=000, all hb_*=0, dead=0, counters=0, last_dirA/B=coast and latched duties=0.
REQ-031 Reset asserted mid-DEADTIME or mid-PWM period SHALL force the outputs low within the reset assertion, with no pending reversal retained.

Structure
REQ-032 Package drive_pkg SHALL hold the dir encodings (COAST/FWD/REV/BRAKE), the state encodings, the command field offsets and the default PERIOD/DEAD/DUTY constants.
REQ-033 One sub-module, pwm_channel, SHALL be instantiated twice; it SHALL take the shared count, duty and mode, and output the enable.

Verification (PERIOD scaled to 1000 and DEAD_CYCLES to 20 for sim)
REQ-034 Scenario: lf_req=1, both motors forward at duty 27 -> gnt=001 after 1 cycle; in1..4=0110; en high for 270 of each 1000 cycles.
REQ-035 Scenario: lf forward active, col_req=1 with both motors reverse at 40 -> gnt=100; dead=1 and hb_*=0 for exactly 20 cycles; then in1..4=1001 with duty 40 from the next period.
REQ-036 Scenario: duty 95 requested -> en high for 800 of 1000 cycles; duty 0 -> en never high.
REQ-037 Scenario: jnc reverse during DEADTIME, then col drops at count 10 -> DEADTIME still ends at 20 and the jnc command is applied with no restart.
REQ-038 Scenario: brake command on A -> in1=in2=0 and en_a=1 constant with no dead-time; all req low -> IDLE and all outputs 0 next cycle.
REQ-039 Scenario: rst_n pulsed low at DEADTIME cycle 5 -> outputs 0 immediately; after release, forward is applied without dead-time since last_dir=coast.
